// File: rtl/summer_uart_tx.sv
// Byte-wide UART transmitter: valid/ready byte input, serial frame out on tx.
// Frame = start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module summer_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST_CYC  = CW'(CLKS_PER_BIT - 1);
  // Illegal settings fall back to no parity and a single stop bit.
  localparam logic           PAR_EN    = (PARITY == 1) || (PARITY == 2);
  localparam logic           PAR_ODD   = (PARITY == 2);
  localparam logic [2:0]     LAST_STOP = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_n;
  logic          tx_n, ready_n, busy_n;
  logic          bit_end;

  assign bit_end = (cyc == LAST_CYC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cyc      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cyc      <= cyc_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      par_bit  <= par_n;
      tx       <= tx_n;
      tx_ready <= ready_n;
      busy     <= busy_n;
    end
  end

  // tx is registered, so each branch loads the level of the bit that starts next.
  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_bit;
    tx_n    = tx;
    ready_n = tx_ready;
    busy_n  = busy;

    if (state == S_IDLE) begin
      tx_n   = 1'b1;
      busy_n = 1'b0;
      if (tx_valid && tx_ready) begin
        shreg_n = tx_data;
        par_n   = (^tx_data) ^ PAR_ODD;
        state_n = S_START;
        cyc_n   = '0;
        bit_n   = '0;
        tx_n    = 1'b0;
        ready_n = 1'b0;
        busy_n  = 1'b1;
      end else begin
        ready_n = 1'b1;
      end
    end else if (!bit_end) begin
      cyc_n = cyc + CW'(1);
    end else begin
      cyc_n = '0;
      case (state)
        S_START: begin
          state_n = S_DATA;
          bit_n   = '0;
          tx_n    = shreg[0];
        end
        S_DATA: begin
          if (bit_cnt == 3'd7) begin
            bit_n = '0;
            if (PAR_EN) begin
              state_n = S_PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            shreg_n = {1'b0, shreg[7:1]};
            tx_n    = shreg[1];
            bit_n   = bit_cnt + 3'd1;
          end
        end
        S_PARITY: begin
          state_n = S_STOP;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
        S_STOP: begin
          tx_n = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            state_n = S_IDLE;
            bit_n   = '0;
            ready_n = 1'b1;
            busy_n  = 1'b0;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
        default: begin
          state_n = S_IDLE;
          bit_n   = '0;
          tx_n    = 1'b1;
          ready_n = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/summer_uart_tx.md
# summer_uart_tx

Byte-wide UART transmitter for the SummerTinyTapeout design. It takes bytes from internal logic over a valid/ready handshake and serialises each one as an 8N1-style frame on one output pin. The frame parity and stop-bit count are set by parameters. It is the transmit end of the project's serial link: the receive side listens on a `ui_in` pin and this block drives a `uo_out` pin, so a host or cocotb bench can read responses at the top-level pins.

## Interface
Parameters:
- `CLKS_PER_BIT`, 87: clock cycles per serial bit (10 MHz / 115200). Must be ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send. Sampled only on the accept edge.
- `tx_valid`  in  1  producer has a byte on `tx_data`.
- `tx_ready`  out  1  registered; the block can accept a byte.
- `tx`  out  1  registered serial line; idles high.
- `busy`  out  1  registered; a frame is in progress.

## Operation
- Reset values: `tx`=1, `tx_ready`=0, `busy`=0, state IDLE, bit counter 0, cycle counter 0.
- `tx_ready` rises on the first edge on which `rst` is low.
- Accept: a byte is accepted on a rising edge where `tx_valid` && `tx_ready`. On that edge:
  - `tx_data` is latched into a shift register.
  - Parity is computed from the latched byte.
  - `tx_ready` goes to 0 and `busy` goes to 1.
  - State moves to START and `tx` goes to 0.
- States: IDLE → START → DATA → (PARITY if `PARITY`≠0) → STOP → IDLE.
  - START: `tx`=0 for one bit time.
  - DATA: 8 bits, LSB first. The shift register shifts right at each bit boundary.
  - PARITY: even mode sends the XOR of the 8 data bits. Odd mode sends its inverse.
  - STOP: `tx`=1 for `STOP_BITS` bit times.
- Bit timing: every bit, including each stop bit, lasts exactly `CLKS_PER_BIT` cycles. A cycle counter of width $clog2(`CLKS_PER_BIT`) runs 0..`CLKS_PER_BIT`-1, and the bit advances on the edge where the counter equals `CLKS_PER_BIT`-1.
- Frame length N = 1 + 8 + (`PARITY`≠0) + `STOP_BITS` bits.
- End of frame: on the edge that ends the last stop bit, state returns to IDLE, `tx_ready` goes to 1, `busy` goes to 0, and `tx` stays 1.
- Boundary conditions:
  - `tx_valid` while `tx_ready`=0 is ignored. Nothing is queued and the producer must hold the byte.
  - Changes to `tx_data` after the accept edge do not affect the frame in flight.
  - `rst` asserted in any state, including mid-bit, aborts the frame. On that edge all registers take their reset values, so `tx`=1 from the next cycle. No partial frame resumes.
  - `rst` and `tx_valid` high on the same edge: reset wins and the byte is not accepted.
  - Illegal `PARITY` value (3) or illegal `STOP_BITS` value: behaves as no parity and 1 stop bit respectively.

## Timing
- Latency: `tx` falls on the accept edge, i.e. it is low in the cycle after acceptance.
- Frame duration: `tx_ready` is high again exactly N·`CLKS_PER_BIT` cycles after the accept edge.
- Back-to-back throughput: with `tx_valid` held high, successive accept edges are N·`CLKS_PER_BIT`+1 cycles apart. There is one IDLE cycle between frames, during which `tx`=1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
1. **Reset.** Hold `rst`=1 for 5 cycles with `tx_valid`=1. `tx`=1, `busy`=0, `tx_ready`=0 throughout. One cycle after `rst`→0, `tx_ready`=1, and no frame has started during reset.
2. **Basic frame.** `CLKS_PER_BIT`=4, no parity, 1 stop; send 0xA5.
   - `tx` reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
   - `busy`=1 for 40 cycles.
   - `tx_ready` returns high 40 cycles after the accept edge.
3. **Parity.** Send 0x07 with 2 stop bits.
   - `PARITY`=1: the bit after the data is 1.
   - `PARITY`=2: the bit after the data is 0.
   - In both cases, 2 high stop bits follow and the frame is 48 cycles.
4. **Back-to-back.** Hold `tx_valid`=1 while presenting 0x00 then 0xFF (`CLKS_PER_BIT`=4, 8N1).
   - Second accept edge is exactly 41 cycles after the first.
   - Exactly one idle-high cycle separates the frames.
   - Decoded bytes are 0x00 and 0xFF.
5. **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 3.
   - `tx`=1 in the next cycle and stays high with no stray bits.
   - `tx_ready`=1 one cycle after release.
   - A following 0x3C transmits correctly.
6. **Ignore while busy.** During a 0x55 frame, toggle `tx_data` and pulse `tx_valid`. The serial output still decodes as 0x55, and no extra frame is sent afterwards.
